// File: rtl/stream_demux.sv
// stream_demux: routes one producer stream into one of two consumer streams.
// Each channel has its own FIFO, so a stalled consumer only blocks the producer
// while the producer is pointing at that consumer's full FIFO.
// Each stored word carries the value of i_counter from its acceptance cycle as a tag.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_counter                    free-running cycle counter (tag source)
//   i_in, i_sel, i_valid         producer word, route select (0 -> ch1, 1 -> ch2), valid
//   o_ready                      producer handshake
//   o_out_x, o_tag_x, o_valid_x  channel x head data/tag/valid (zeroed when empty)
//   i_ready_x                    channel x consumer ready
//   o_count_x                    words accepted into channel x (wrapping)
module stream_demux #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_counter,
  input  logic [DATA_W-1:0] i_in,
  input  logic              i_sel,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_out_1,
  output logic [31:0]       o_tag_1,
  output logic              o_valid_1,
  input  logic              i_ready_1,
  output logic [DATA_W-1:0] o_out_2,
  output logic [31:0]       o_tag_2,
  output logic              o_valid_2,
  input  logic              i_ready_2,
  output logic [CNT_W-1:0]  o_count_1,
  output logic [CNT_W-1:0]  o_count_2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // index 0 = channel 1, index 1 = channel 2
  logic [DATA_W-1:0] data_q   [2][DEPTH];
  logic [DATA_W-1:0] data_d   [2][DEPTH];
  logic [31:0]       tag_q    [2][DEPTH];
  logic [31:0]       tag_d    [2][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [OCC_W-1:0]  occ_q    [2];
  logic [OCC_W-1:0]  occ_d    [2];
  logic [CNT_W-1:0]  count_q  [2];
  logic [CNT_W-1:0]  count_d  [2];

  logic [1:0] valid;
  logic [1:0] full;
  logic [1:0] cons_ready;
  logic [1:0] pop;
  logic [1:0] push;
  logic       ready;

  // Handshake: a full selected channel may still accept when it pops this
  // cycle; the unselected channel never influences o_ready.
  always_comb begin
    valid      = '0;
    full       = '0;
    cons_ready = {i_ready_2, i_ready_1};
    for (int c = 0; c < 2; c++) begin
      valid[c] = (occ_q[c] != '0);
      full[c]  = (occ_q[c] == OCC_FULL);
    end
    pop   = valid & cons_ready;
    ready = !i_rst && (!full[i_sel] || pop[i_sel]);
    push  = '0;
    if (i_valid && ready) begin
      push[i_sel] = 1'b1;
    end
  end

  assign o_ready = ready;

  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        data_d[c][wr_ptr_q[c]] = i_in;
        tag_d[c][wr_ptr_q[c]]  = i_counter;
        wr_ptr_d[c]            = wr_ptr_q[c] + PTR_W'(1);
        count_d[c]             = count_q[c] + CNT_W'(1);
      end
      if (pop[c]) begin
        rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(1);
      end
      case ({push[c], pop[c]})
        2'b10:   occ_d[c] = occ_q[c] + OCC_W'(1);
        2'b01:   occ_d[c] = occ_q[c] - OCC_W'(1);
        default: occ_d[c] = occ_q[c];
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        occ_q[c]    <= '0;
        count_q[c]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are never visible because the
  // outputs are masked whenever a channel is empty.
  always_ff @(posedge i_clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  assign o_valid_1 = valid[0];
  assign o_out_1   = valid[0] ? data_q[0][rd_ptr_q[0]] : '0;
  assign o_tag_1   = valid[0] ? tag_q[0][rd_ptr_q[0]]  : '0;
  assign o_valid_2 = valid[1];
  assign o_out_2   = valid[1] ? data_q[1][rd_ptr_q[1]] : '0;
  assign o_tag_2   = valid[1] ? tag_q[1][rd_ptr_q[1]]  : '0;
  assign o_count_1 = count_q[0];
  assign o_count_2 = count_q[1];

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Inverse of the datapath 2:1 select. One 32-bit producer stream is routed to one of two consumer streams by a select bit.
- Each consumer side has its own small FIFO, so a stalled consumer does not block traffic headed to the other side, except while the selected side is full.
- Each word carries the free-running cycle counter value from its acceptance cycle as a debug tag.
- Sits between the instruction/result producer and the two downstream consumers, for example the writeback path and the trace/debug path.

Parameters:
- DATA_W, 32: data width.
- DEPTH, 2: entries per channel FIFO. Must be a power of two and at least 2.
- CNT_W, 16: width of the per-channel accepted-word counters.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_counter  in  32  cycle counter; sampled as the tag of each accepted word.
- i_in  in  DATA_W  input data.
- i_sel  in  1  route select: 0 = channel 1, 1 = channel 2.
- i_valid  in  1  input word valid.
- o_ready  out  1  input word can be accepted this cycle.
- o_out_1  out  DATA_W  channel 1 head data.
- o_tag_1  out  32  channel 1 head tag.
- o_valid_1  out  1  channel 1 head valid.
- i_ready_1  in  1  channel 1 consumer ready.
- o_out_2  out  DATA_W  channel 2 head data.
- o_tag_2  out  32  channel 2 head tag.
- o_valid_2  out  1  channel 2 head valid.
- i_ready_2  in  1  channel 2 consumer ready.
- o_count_1  out  CNT_W  words accepted into channel 1.
- o_count_2  out  CNT_W  words accepted into channel 2.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge):
  - Both FIFOs are emptied and all pointers and occupancies are zeroed.
  - o_valid_x=0, o_out_x=0, o_tag_x=0, o_count_x=0.
  - o_ready is forced to 0 while i_rst=1.
  - In the first cycle after deassertion, o_ready=1.
- Reset mid-operation: all buffered words are discarded, not delivered. Counters restart at 0.
- Accept condition: i_valid && o_ready at a rising edge. The pair {i_in, i_counter} is written to the tail of the FIFO selected by i_sel.
  - i_sel is only meaningful when i_valid=1.
  - i_sel may change every cycle; each word is routed by its own i_sel.
- o_ready (combinational from i_sel, the occupancies and i_ready_x):
  - o_ready = !full(sel) || (o_valid_sel && i_ready_sel).
  - This means a push into a full channel is allowed in the same cycle that channel pops.
  - The state of the unselected channel never affects o_ready.
- Pop: channel x pops its head at a rising edge when o_valid_x && i_ready_x.
- Outputs:
  - o_valid_x = (occupancy_x != 0), registered.
  - o_out_x and o_tag_x are the head entry when o_valid_x=1, and are forced to 0 when o_valid_x=0.
  - There is no fall-through path. A word accepted at edge N appears on the outputs after edge N, i.e. 1 cycle of latency into an empty FIFO.
- Ordering: words within a channel are delivered strictly in acceptance order. There is no ordering relation between the two channels.
- Simultaneous events:
  - Push and pop on the same channel in one cycle: occupancy is unchanged, the head advances and the new word goes to the tail.
  - Push on one channel with a pop on the other: the two are fully independent.
  - Both channels may pop in the same cycle.
- Full: with occupancy_x = DEPTH, i_sel selecting x and i_ready_x=0, o_ready=0. The input word must be held by the producer and nothing is written.
- Empty: when a channel is empty, o_valid_x=0 and i_ready_x is ignored. A pop of an empty FIFO never occurs.
- Pointers: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- Counters: o_count_x increments by 1 on each accept into channel x and wraps from 2^CNT_W-1 to 0. The counters are not affected by pops.

Test Plan:
1. Reset release, then a single push.
   - Stimulus: i_rst high 2 cycles; then i_valid=1, i_sel=0, i_in=32'hDEADBEEF, i_counter=32'h10, i_ready_1=1.
   - Required: o_ready=0 during reset. The next cycle shows o_valid_1=1, o_out_1=DEADBEEF, o_tag_1=10, o_count_1=1. o_valid_2=0 and o_out_2=0 throughout.
2. Fill and backpressure.
   - Stimulus: i_ready_2=0; push 3 words 1,2,3 with i_sel=1.
   - Required: words 1 and 2 are accepted and o_ready=0 for word 3. Then i_ready_2=1: 1 and 2 pop in order, word 3 is accepted in the pop cycle, and o_count_2 ends at 3.
3. Channel isolation.
   - Stimulus: channel 2 is full with i_ready_2=0; push words A,B with i_sel=0 and i_ready_1=1.
   - Required: both words are accepted back-to-back and appear on channel 1. Channel 2 contents are unchanged.
4. Alternating select with both consumers ready.
   - Stimulus: push 8 words with i_sel toggling 0,1,0,1…
   - Required: channel 1 receives words 0,2,4,6 and channel 2 receives words 1,3,5,7, each with the correct tag. o_ready=1 every cycle, and each o_count_x = 4.
5. Reset mid-operation.
   - Stimulus: both FIFOs hold 2 words; assert i_rst for 1 cycle.
   - Required: the next cycle shows o_valid_1=o_valid_2=0, o_count_x=0 and o_ready=1. The discarded words never appear.
6. Counter wrap.
   - Stimulus: CNT_W=4; push 17 words to channel 1 with i_ready_1=1.
   - Required: o_count_1 reads 15, then 0, then 1 after the 15th, 16th and 17th accepts.
